// File: rtl/mux_2to1_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mux_2to1_rr_arb
//  Brief    : Round-robin arbitrated 2:1 valid/ready stage with registered out
//  Revision : 1.0 - initial release
// ============================================================================
module mux_2to1_rr_arb #(
    parameter int width     = 16,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width-1:0]     a,
    input  logic                 valid_a,
    output logic                 ready_a,
    input  logic [width-1:0]     b,
    input  logic                 valid_b,
    output logic                 ready_b,
    output logic [width-1:0]     c,
    output logic                 valid_c,
    input  logic                 ready_c,
    output logic                 sel,
    input  logic                 cnt_clr,
    output logic [cnt_width-1:0] cnt_a,
    output logic [cnt_width-1:0] cnt_b
);

    localparam logic [0:0]           C_EMPTY   = 1'b0;
    localparam logic [0:0]           C_FULL    = 1'b1;
    localparam logic [cnt_width-1:0] C_CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic                 r_last;
    logic [width-1:0]     r_c;
    logic                 r_sel;
    logic [cnt_width-1:0] r_cnt_a;
    logic [cnt_width-1:0] r_cnt_b;
    logic                 w_can_load;
    logic                 w_grant_a;
    logic                 w_grant_b;
    logic                 w_grant;

    // The output register may take a new word when empty or draining this cycle.
    assign w_can_load = (r_state == C_EMPTY) || ready_c;
    assign w_grant    = w_grant_a || w_grant_b;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_can_load) begin
            if (valid_a && valid_b) begin
                w_grant_a = r_last;
                w_grant_b = !r_last;
            end else begin
                w_grant_a = valid_a;
                w_grant_b = valid_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = C_FULL;
        end else if ((r_state == C_FULL) && ready_c) begin
            w_state_nxt = C_EMPTY;
        end
    end

    always_comb begin
        valid_c = (r_state == C_FULL);
        ready_a = w_grant_a;
        ready_b = w_grant_b;
    end

    // last resets to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c    <= '0;
            r_sel  <= 1'b0;
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_c    <= w_grant_b ? b : a;
            r_sel  <= w_grant_b;
            r_last <= w_grant_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (cnt_clr) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_grant_a) begin
                r_cnt_a <= r_cnt_a + C_CNT_ONE;
            end
            if (w_grant_b) begin
                r_cnt_b <= r_cnt_b + C_CNT_ONE;
            end
        end
    end

    assign c     = r_c;
    assign sel   = r_sel;
    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_2to1_rr_arb
//  Brief    : Self-checking bench for mux_2to1_rr_arb with a behavioural model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2to1_rr_arb;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic        valid_a;
    logic        ready_a;
    logic [15:0] b;
    logic        valid_b;
    logic        ready_b;
    logic [15:0] c;
    logic        valid_c;
    logic        ready_c;
    logic        sel;
    logic        cnt_clr;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    // Model of the stage: output slot contents, fairness pointer, counters.
    bit m_valid;
    int m_c;
    bit m_sel;
    bit m_last;
    int m_cnt_a;
    int m_cnt_b;

    mux_2to1_rr_arb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .valid_a (valid_a),
        .ready_a (ready_a),
        .b       (b),
        .valid_b (valid_b),
        .ready_b (ready_b),
        .c       (c),
        .valid_c (valid_c),
        .ready_c (ready_c),
        .sel     (sel),
        .cnt_clr (cnt_clr),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_c     = 0;
        m_sel   = 1'b0;
        m_last  = 1'b1;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".c"},       {16'h0, c},        m_c);
        chk({tag, ".valid_c"}, {31'h0, valid_c},  {31'h0, m_valid});
        chk({tag, ".sel"},     {31'h0, sel},      {31'h0, m_sel});
        chk({tag, ".cnt_a"},   {16'h0, cnt_a},    m_cnt_a);
        chk({tag, ".cnt_b"},   {16'h0, cnt_b},    m_cnt_b);
    endtask

    // Apply the current inputs for one clock: check readies, clock, check state.
    task automatic cycle(input string tag);
        bit ga, gb, slot_free;
        int da, db;
        ga = 1'b0;
        gb = 1'b0;
        slot_free = !m_valid || ready_c;
        if (slot_free && valid_a && valid_b) begin
            ga = m_last;
            gb = !m_last;
        end else if (slot_free) begin
            ga = valid_a;
            gb = valid_b;
        end
        da = int'(a);
        db = int'(b);
        #1;
        chk({tag, ".ready_a"}, {31'h0, ready_a}, {31'h0, ga});
        chk({tag, ".ready_b"}, {31'h0, ready_b}, {31'h0, gb});
        @(posedge clk);
        if (ga || gb) begin
            m_c     = gb ? db : da;
            m_sel   = gb;
            m_last  = gb;
            m_valid = 1'b1;
            if (ga) m_cnt_a = (m_cnt_a + 1) % 65536;
            if (gb) m_cnt_b = (m_cnt_b + 1) % 65536;
        end else if (m_valid && ready_c) begin
            m_valid = 1'b0;
        end
        if (cnt_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end
        #1;
        chk_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk_outputs("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_c [4];
        logic        exp_s [4];

        rst_n   = 1'b0;
        a       = 16'h0;
        b       = 16'h0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        ready_c = 1'b0;
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single source
        a = 16'hA000; valid_a = 1'b1; valid_b = 1'b0; ready_c = 1'b1;
        cycle("single");
        chk("single.c_const", {16'h0, c}, 32'h0000A000);
        chk("single.cnt_a_const", {16'h0, cnt_a}, 32'h1);

        // Contention: A first after reset, then alternating
        do_reset();
        exp_c[0] = 16'hB000; exp_c[1] = 16'hC000; exp_c[2] = 16'hB000; exp_c[3] = 16'hC000;
        exp_s[0] = 1'b0;     exp_s[1] = 1'b1;     exp_s[2] = 1'b0;     exp_s[3] = 1'b1;
        a = 16'hB000; b = 16'hC000; valid_a = 1'b1; valid_b = 1'b1; ready_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("contend");
            chk("contend.c_seq", {16'h0, c}, {16'h0, exp_c[i]});
            chk("contend.sel_seq", {31'h0, sel}, {31'h0, exp_s[i]});
        end
        chk("contend.cnt_a_const", {16'h0, cnt_a}, 32'h2);
        chk("contend.cnt_b_const", {16'h0, cnt_b}, 32'h2);

        // Backpressure
        a = 16'hD000; valid_a = 1'b1; valid_b = 1'b0; ready_c = 1'b1;
        cycle("bp_fill");
        valid_a = 1'b0; b = 16'hE000; valid_b = 1'b1; ready_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_hold.c_const", {16'h0, c}, 32'h0000D000);
            chk("bp_hold.ready_b_const", {31'h0, ready_b}, 32'h0);
        end
        ready_c = 1'b1;
        cycle("bp_release");
        chk("bp_release.c_const", {16'h0, c}, 32'h0000E000);
        chk("bp_release.valid_const", {31'h0, valid_c}, 32'h1);

        // Drain
        valid_b = 1'b0;
        cycle("drain");
        chk("drain.valid_const", {31'h0, valid_c}, 32'h0);
        chk("drain.c_const", {16'h0, c}, 32'h0000E000);

        // Clear with a simultaneous accept
        a = 16'h1234; valid_a = 1'b1; cnt_clr = 1'b1;
        cycle("clr_accept");
        chk("clr_accept.cnt_a_const", {16'h0, cnt_a}, 32'h0);
        cnt_clr = 1'b0;

        // Bring cnt_a to 0xFFFF with a long unchecked run, then wrap
        repeat (65535) @(posedge clk);
        m_cnt_a = 65535;
        m_c     = 32'h1234;
        m_sel   = 1'b0;
        m_last  = 1'b0;
        m_valid = 1'b1;
        #1;
        chk("wrap.preload", {16'h0, cnt_a}, 32'h0000FFFF);
        cycle("wrap");
        chk("wrap.cnt_a_const", {16'h0, cnt_a}, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            a       = 16'($urandom);
            b       = 16'($urandom);
            valid_a = 1'($urandom_range(0, 1));
            valid_b = 1'($urandom_range(0, 1));
            ready_c = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            cycle("rand");
        end
        cnt_clr = 1'b0;

        // Asynchronous reset mid-cycle while FULL
        a = 16'h5A5A; valid_a = 1'b1; valid_b = 1'b0; ready_c = 1'b0;
        cycle("pre_rst");
        a = 16'($urandom); b = 16'($urandom);
        valid_a = 1'($urandom_range(0, 1)); valid_b = 1'($urandom_range(0, 1));
        ready_c = 1'($urandom_range(0, 1));
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_outputs("async_rst");
        rst_n = 1'b1;
        a = 16'h0A0A; b = 16'h0B0B; valid_a = 1'b1; valid_b = 1'b1; ready_c = 1'b1;
        cycle("post_rst");
        chk("post_rst.c_const", {16'h0, c}, 32'h00000A0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
